// File: rtl/ii_gen.sv
// Integral-image generator: turns a raster pixel stream into the zero-padded integral
// image and squared integral image of one detection window, as two valid/ready streams.
module ii_gen #(
  parameter int W_PIX         = 8,
  parameter int W_II          = 18,
  parameter int W_SII         = 26,
  parameter int WINDOW_WIDTH  = 25,
  parameter int WINDOW_HEIGHT = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [W_PIX-1:0] pix_data,
  output logic             ii_valid,
  input  logic             ii_ready,
  output logic [W_II-1:0]  ii_data,
  output logic [1:0]       ii_eot,
  output logic             sii_valid,
  input  logic             sii_ready,
  output logic [W_SII-1:0] sii_data,
  output logic [1:0]       sii_eot
);

  localparam int XW = $clog2(WINDOW_WIDTH);
  localparam int YW = $clog2(WINDOW_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WINDOW_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(WINDOW_HEIGHT - 1);

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [W_II-1:0]  rs;
  logic [W_SII-1:0] rs2;
  logic [W_II-1:0]  line_ii  [1:WINDOW_WIDTH-1];
  logic [W_SII-1:0] line_sii [1:WINDOW_WIDTH-1];

  logic             slot_free;
  logic             pad;
  logic             emit;
  logic             accept;
  logic             x_last;
  logic             y_last;
  logic [W_SII-1:0] pix_sq;
  logic [W_II-1:0]  rs_next;
  logic [W_SII-1:0] rs2_next;
  logic [W_II-1:0]  ii_next;
  logic [W_SII-1:0] sii_next;

  // A new element loads only once both channels have drained their previous one.
  always_comb begin
    slot_free = (!ii_valid || ii_ready) && (!sii_valid || sii_ready);
    pad       = (x == '0) || (y == '0);
    x_last    = (x == X_LAST);
    y_last    = (y == Y_LAST);
    pix_ready = slot_free && !pad;
    accept    = pix_valid && pix_ready;
    emit      = slot_free && (pad || pix_valid);
    pix_sq    = W_SII'(pix_data) * W_SII'(pix_data);
    rs_next   = ((x == XW'(1)) ? '0 : rs) + W_II'(pix_data);
    rs2_next  = ((x == XW'(1)) ? '0 : rs2) + pix_sq;
    ii_next   = '0;
    sii_next  = '0;
    if (!pad) begin
      ii_next  = rs_next + line_ii[x];
      sii_next = rs2_next + line_sii[x];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x         <= '0;
      y         <= '0;
      rs        <= '0;
      rs2       <= '0;
      ii_valid  <= 1'b0;
      ii_data   <= '0;
      ii_eot    <= '0;
      sii_valid <= 1'b0;
      sii_data  <= '0;
      sii_eot   <= '0;
    end else begin
      if (accept) begin
        rs  <= rs_next;
        rs2 <= rs2_next;
      end
      if (emit) begin
        ii_valid  <= 1'b1;
        ii_data   <= ii_next;
        ii_eot    <= {x_last && y_last, x_last};
        sii_valid <= 1'b1;
        sii_data  <= sii_next;
        sii_eot   <= {x_last && y_last, x_last};
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end else begin
        if (ii_ready)  ii_valid  <= 1'b0;
        if (sii_ready) sii_valid <= 1'b0;
      end
    end
  end

  // The padding row zeroes the column sums, so the buffers need no reset of their own.
  always_ff @(posedge clk) begin
    if (emit && (y == '0) && (x != '0)) begin
      line_ii[x]  <= '0;
      line_sii[x] <= '0;
    end else if (accept) begin
      line_ii[x]  <= ii_next;
      line_sii[x] <= sii_next;
    end
  end

endmodule

// File: tb/tb_ii_gen.sv
// Self-checking bench for ii_gen: golden integral images from a 2-D prefix-sum model,
// randomized pixels and ready gaps, plus hand-written corner-case sequences.
module tb_ii_gen;

  localparam int WW   = 25;
  localparam int WH   = 25;
  localparam int NOUT = WW * WH;
  localparam int NPIX = (WW - 1) * (WH - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = '0;
  logic        ii_valid;
  logic        ii_ready = 1'b0;
  logic [17:0] ii_data;
  logic [1:0]  ii_eot;
  logic        sii_valid;
  logic        sii_ready = 1'b0;
  logic [25:0] sii_data;
  logic [1:0]  sii_eot;

  ii_gen #(
    .W_PIX(8), .W_II(18), .W_SII(26), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .ii_valid(ii_valid), .ii_ready(ii_ready), .ii_data(ii_data), .ii_eot(ii_eot),
    .sii_valid(sii_valid), .sii_ready(sii_ready), .sii_data(sii_data), .sii_eot(sii_eot)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     data;
    logic [1:0] eot;
  } exp_t;

  typedef struct {
    int         win;
    int         x;
    int         y;
    longint     ii;
    longint     sii;
    logic [1:0] eot;
  } vec_t;

  exp_t   exp_ii[$];
  exp_t   exp_sii[$];
  int     pixq[$];
  int     errors = 0;
  int     checks = 0;
  longint cap_ii [NOUT];
  longint cap_sii[NOUT];
  logic [1:0] cap_eot[NOUT];
  int     ii_cnt, sii_cnt, pix_cnt;
  logic   prev_iv, prev_ir, prev_sv, prev_sr;
  logic [17:0] prev_id;
  logic [25:0] prev_sd;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Golden model: ii(x,y) = p + ii(x-1,y) + ii(x,y-1) - ii(x-1,y-1), zero on row/column 0.
  task automatic load_window(input int mode);
    int     p[WH][WW];
    longint g[WH][WW];
    longint g2[WH][WW];
    exp_t   e;
    for (int j = 1; j < WH; j++)
      for (int i = 1; i < WW; i++) begin
        case (mode)
          0: p[j][i] = 1;
          1: p[j][i] = 255;
          default: p[j][i] = int'($urandom_range(0, 255));
        endcase
        pixq.push_back(p[j][i]);
      end
    for (int yy = 0; yy < WH; yy++)
      for (int xx = 0; xx < WW; xx++) begin
        if (xx == 0 || yy == 0) begin
          g[yy][xx]  = 0;
          g2[yy][xx] = 0;
        end else begin
          g[yy][xx]  = longint'(p[yy][xx]) + g[yy][xx-1] + g[yy-1][xx] - g[yy-1][xx-1];
          g2[yy][xx] = longint'(p[yy][xx]) * longint'(p[yy][xx])
                       + g2[yy][xx-1] + g2[yy-1][xx] - g2[yy-1][xx-1];
        end
        e.eot  = {(xx == WW-1) && (yy == WH-1), xx == WW-1};
        e.data = g[yy][xx];
        exp_ii.push_back(e);
        e.data = g2[yy][xx];
        exp_sii.push_back(e);
      end
  endtask

  task automatic observe();
    exp_t e;
    if (prev_iv && !prev_ir) begin
      check_output("ii_hold_valid", 64'(ii_valid), 64'd1);
      check_output("ii_hold_data", 64'(ii_data), 64'(prev_id));
    end
    if (prev_sv && !prev_sr) begin
      check_output("sii_hold_valid", 64'(sii_valid), 64'd1);
      check_output("sii_hold_data", 64'(sii_data), 64'(prev_sd));
    end
    if (pix_valid && pix_ready) begin
      void'(pixq.pop_front());
      pix_cnt++;
    end
    if (ii_valid && ii_ready) begin
      if (exp_ii.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL ii_extra: got output %0d, expected none", ii_data);
      end else begin
        e = exp_ii.pop_front();
        check_output("ii_data", 64'(ii_data), 64'(e.data));
        check_output("ii_eot", 64'(ii_eot), 64'(e.eot));
      end
      cap_ii[ii_cnt % NOUT]  = longint'(ii_data);
      cap_eot[ii_cnt % NOUT] = ii_eot;
      ii_cnt++;
    end
    if (sii_valid && sii_ready) begin
      if (exp_sii.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL sii_extra: got output %0d, expected none", sii_data);
      end else begin
        e = exp_sii.pop_front();
        check_output("sii_data", 64'(sii_data), 64'(e.data));
        check_output("sii_eot", 64'(sii_eot), 64'(e.eot));
      end
      cap_sii[sii_cnt % NOUT] = longint'(sii_data);
      sii_cnt++;
    end
    prev_iv = ii_valid;  prev_ir = ii_ready;  prev_id = ii_data;
    prev_sv = sii_valid; prev_sr = sii_ready; prev_sd = sii_data;
  endtask

  task automatic apply_stimulus(input logic pv, input logic ir, input logic sr);
    @(posedge clk);
    #1;
    pix_valid = pv && (pixq.size() > 0);
    pix_data  = (pixq.size() > 0) ? 8'(pixq[0]) : 8'h00;
    ii_ready  = ir;
    sii_ready = sr;
    @(negedge clk);
    observe();
  endtask

  task automatic run_stream(input int vprob, input int rprob, input int maxcyc, output int cyc);
    cyc = 0;
    while ((exp_ii.size() > 0 || exp_sii.size() > 0) && cyc < maxcyc) begin
      apply_stimulus($urandom_range(0, 99) < vprob, $urandom_range(0, 99) < rprob,
                     $urandom_range(0, 99) < rprob);
      cyc++;
    end
    if (cyc >= maxcyc) begin
      checks++; errors++;
      $display("[TB] FAIL stream_timeout: got %0d outputs left, expected 0", exp_ii.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pix_valid = 1'b0; ii_ready = 1'b0; sii_ready = 1'b0; pix_data = '0;
    pixq.delete(); exp_ii.delete(); exp_sii.delete();
    prev_iv = 0; prev_ir = 0; prev_sv = 0; prev_sr = 0; prev_id = '0; prev_sd = '0;
    ii_cnt = 0; sii_cnt = 0; pix_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_ii_valid", 64'(ii_valid), 64'd0);
    check_output("rst_sii_valid", 64'(sii_valid), 64'd0);
    check_output("rst_pix_ready", 64'(pix_ready), 64'd0);
    check_output("rst_ii_data", 64'(ii_data), 64'd0);
    check_output("rst_sii_eot", 64'(sii_eot), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_table(input int win, input vec_t vecs[10]);
    int k;
    foreach (vecs[n]) begin
      if (vecs[n].win == win) begin
        k = vecs[n].y * WW + vecs[n].x;
        check_output($sformatf("tbl_ii(%0d,%0d)", vecs[n].x, vecs[n].y), 64'(cap_ii[k]), 64'(vecs[n].ii));
        check_output($sformatf("tbl_sii(%0d,%0d)", vecs[n].x, vecs[n].y), 64'(cap_sii[k]), 64'(vecs[n].sii));
        check_output($sformatf("tbl_eot(%0d,%0d)", vecs[n].x, vecs[n].y), 64'(cap_eot[k]), 64'(vecs[n].eot));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got no finish, expected finish within 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int   cyc;
    logic [17:0] held;

    vecs[0] = '{0,  0,  0,      0,        0, 2'b00};
    vecs[1] = '{0, 24,  0,      0,        0, 2'b01};
    vecs[2] = '{0,  1,  1,      1,        1, 2'b00};
    vecs[3] = '{0,  5,  7,     35,       35, 2'b00};
    vecs[4] = '{0, 24, 24,    576,      576, 2'b11};
    vecs[5] = '{1,  1,  1,    255,    65025, 2'b00};
    vecs[6] = '{1, 24,  1,   6120,  1560600, 2'b01};
    vecs[7] = '{1, 24, 24, 146880, 37454400, 2'b11};
    vecs[8] = '{1,  0, 12,      0,        0, 2'b00};
    vecs[9] = '{1, 10, 10,  25500,  6502500, 2'b00};

    // All ones, full throughput.
    do_reset();
    load_window(0);
    run_stream(100, 100, 2000, cyc);
    check_output("ones_cycles", 64'(cyc), 64'(NOUT));
    check_output("ones_pixels", 64'(pix_cnt), 64'(NPIX));
    check_table(0, vecs);

    // All 255, padding row/column must stay zero.
    do_reset();
    load_window(1);
    run_stream(100, 100, 2000, cyc);
    check_table(1, vecs);
    for (int k = 0; k < NOUT; k++)
      if (k < WW || (k % WW) == 0)
        check_output("max_pad_zero", 64'(cap_ii[k] + cap_sii[k]), 64'd0);

    // Pad stretch at window start, then the first pixel.
    do_reset();
    pix_valid = 1'b1; pix_data = 8'd7; ii_ready = 1'b1; sii_ready = 1'b1;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (k <= 25) check_output("pad_pix_ready", 64'(pix_ready), 64'd0);
      if (k >= 1 && k <= 26) begin
        check_output("pad_ii_valid", 64'(ii_valid), 64'd1);
        check_output("pad_ii_data", 64'(ii_data), 64'd0);
      end
      if (k == 26) check_output("first_pix_ready", 64'(pix_ready), 64'd1);
      if (k == 27) begin
        check_output("first_ii", 64'(ii_data), 64'd7);
        check_output("first_sii", 64'(sii_data), 64'd49);
        check_output("first_eot", 64'(ii_eot), 64'd0);
      end
    end

    // ii stalled while sii keeps draining.
    do_reset();
    load_window(2);
    for (int k = 0; k < 200 && ii_cnt < 100; k++) apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("stall_prefill", 64'(ii_cnt), 64'd100);
    held = '0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1);
      if (k == 0) begin
        held = ii_data;
        check_output("stall_ii_valid", 64'(ii_valid), 64'd1);
      end else begin
        check_output("stall_sii_valid", 64'(sii_valid), 64'd0);
        check_output("stall_pix_ready", 64'(pix_ready), 64'd0);
        check_output("stall_ii_held", 64'(ii_data), 64'(held));
      end
    end
    run_stream(70, 70, 5000, cyc);
    check_output("stall_pixels", 64'(pix_cnt), 64'(NPIX));

    // Two windows back to back with random gaps.
    do_reset();
    load_window(2);
    load_window(2);
    run_stream(80, 75, 8000, cyc);
    check_output("b2b_pixels", 64'(pix_cnt), 64'(2 * NPIX));
    check_output("b2b_last_eot", 64'(cap_eot[NOUT-1]), 64'd3);

    // Reset asserted with the counters at (12,9).
    do_reset();
    load_window(2);
    for (int k = 0; k < 400 && ii_cnt < 9 * WW + 12; k++) apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("midrst_prefill", 64'(ii_cnt), 64'(9 * WW + 12));
    #2 rst = 1'b0;
    #1;
    check_output("midrst_ii_valid", 64'(ii_valid), 64'd0);
    check_output("midrst_sii_valid", 64'(sii_valid), 64'd0);
    check_output("midrst_pix_ready", 64'(pix_ready), 64'd0);
    do_reset();
    load_window(2);
    run_stream(85, 85, 5000, cyc);
    check_output("midrst_pixels", 64'(pix_cnt), 64'(NPIX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
